// File: rtl/toggle_period_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | toggle_period_monitor                                                      |
// | Measures half-periods of an asynchronous toggle, flags short/long ones,    |
// | counts errors and reports lock.                                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module toggle_period_monitor #(
  parameter int CNT_W    = 16,
  parameter int EXP_HALF = 5,
  parameter int TOL      = 1,
  parameter int LOCK_N   = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             toggle_in,
  input  logic             enable,
  output logic             level,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             too_short,
  output logic             too_long,
  output logic             lock,
  output logic [7:0]       err_count
);

  localparam int               c_run_w   = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] c_lo      = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] c_hi      = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(EXP_HALF + TOL + 1);
  localparam logic [c_run_w-1:0] c_lock_n = c_run_w'(LOCK_N);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic [CNT_W-1:0]   r_count;
  logic [c_run_w-1:0] r_good_run;

  logic               w_edge;
  logic               w_short;
  logic               w_long;
  logic               w_good;
  logic               w_err_evt;
  logic [c_run_w-1:0] w_run_inc;

  assign level     = r_s2;
  assign w_edge    = r_s2 ^ r_s3;
  assign w_short   = (r_count < c_lo);
  assign w_long    = (r_count > c_hi);
  assign w_good    = !w_short && !w_long;
  assign w_run_inc = (r_good_run == c_lock_n) ? r_good_run : r_good_run + c_run_w'(1);

  // An edge on the timeout cycle is measured (as long) rather than timed out.
  assign w_err_evt = enable && (r_state == S_MEASURE) &&
                     (w_edge ? (w_short || w_long) : (r_count == c_timeout));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_good_run   <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      too_short    <= 1'b0;
      too_long     <= 1'b0;
      lock         <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      r_s1         <= toggle_in;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      period_valid <= 1'b0;
      too_short    <= 1'b0;
      too_long     <= 1'b0;

      if (w_err_evt && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      if (!enable) begin
        r_state    <= S_IDLE;
        r_count    <= '0;
        r_good_run <= '0;
        lock       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_count    <= '0;
            r_good_run <= '0;
            lock       <= 1'b0;
            r_state    <= S_ARM;
          end
          S_ARM: begin
            if (w_edge) begin
              r_count <= CNT_W'(1);
              r_state <= S_MEASURE;
            end
          end
          S_MEASURE: begin
            if (w_edge) begin
              period       <= r_count;
              period_valid <= 1'b1;
              too_short    <= w_short;
              too_long     <= w_long;
              r_count      <= CNT_W'(1);
              if (w_good) begin
                r_good_run <= w_run_inc;
                lock       <= (w_run_inc == c_lock_n);
              end else begin
                r_good_run <= '0;
                lock       <= 1'b0;
              end
            end else if (r_count == c_timeout) begin
              too_long   <= 1'b1;
              r_good_run <= '0;
              lock       <= 1'b0;
              r_count    <= '0;
              r_state    <= S_ARM;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_toggle_period_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_toggle_period_monitor                                                   |
// | Directed bench for toggle_period_monitor with default parameters.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_toggle_period_monitor;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b1;
  logic        toggle_in = 1'b0;
  logic        enable    = 1'b0;
  logic        level;
  logic [15:0] period;
  logic        period_valid;
  logic        too_short;
  logic        too_long;
  logic        lock;
  logic [7:0]  err_count;

  int vectors     = 0;
  int miscompares = 0;

  toggle_period_monitor dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .toggle_in    (toggle_in),
    .enable       (enable),
    .level        (level),
    .period       (period),
    .period_valid (period_valid),
    .too_short    (too_short),
    .too_long     (too_long),
    .lock         (lock),
    .err_count    (err_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Flip the toggle, then hold it for h cycles. The measurement caused by this
  // flip appears on the third sample; exp_* describe that measurement.
  task automatic flip_and_wait(input int h, input bit exp_v, input int exp_p,
                               input bit exp_s, input bit exp_l, input bit exp_lock,
                               input int exp_err, input string tag);
    toggle_in = ~toggle_in;
    for (int i = 1; i <= h; i++) begin
      step();
      vectors++;
      if (period_valid !== ((i == 3) ? exp_v : 1'b0)) begin
        miscompares++;
        $display("FAIL %s step%0d period_valid got %b want %b", tag, i, period_valid, (i == 3) ? exp_v : 1'b0);
      end
      vectors++;
      if (too_short !== ((i == 3) ? exp_s : 1'b0)) begin
        miscompares++;
        $display("FAIL %s step%0d too_short got %b want %b", tag, i, too_short, (i == 3) ? exp_s : 1'b0);
      end
      vectors++;
      if (too_long !== ((i == 3) ? exp_l : 1'b0)) begin
        miscompares++;
        $display("FAIL %s step%0d too_long got %b want %b", tag, i, too_long, (i == 3) ? exp_l : 1'b0);
      end
      if (i == 3 && exp_v) begin
        vectors++;
        if (period !== 16'(exp_p)) begin
          miscompares++;
          $display("FAIL %s period got %0d want %0d", tag, period, exp_p);
        end
      end
      if (i >= 2) begin
        vectors++;
        if (level !== toggle_in) begin
          miscompares++;
          $display("FAIL %s step%0d level got %b want %b", tag, i, level, toggle_in);
        end
      end
      if (i >= 3) begin
        vectors++;
        if (lock !== exp_lock) begin
          miscompares++;
          $display("FAIL %s step%0d lock got %b want %b", tag, i, lock, exp_lock);
        end
        vectors++;
        if (err_count !== 8'(exp_err)) begin
          miscompares++;
          $display("FAIL %s step%0d err_count got %0d want %0d", tag, i, err_count, exp_err);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({level, period, period_valid, too_short, too_long, lock, err_count} !== 29'd0) begin
      miscompares++;
      $display("FAIL %s outputs got lvl=%b per=%0d v=%b s=%b l=%b lk=%b err=%0d want all 0",
               tag, level, period, period_valid, too_short, too_long, lock, err_count);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) step();
    check_all_zero("reset_hold");
    #3 reset_n = 1'b1;
    enable = 1'b1;
    repeat (3) step();
    check_all_zero("reset_release");
  endtask

  task automatic test_nominal();
    flip_and_wait(5, 0, 0, 0, 0, 0, 0, "nom_arm");
    flip_and_wait(5, 1, 5, 0, 0, 0, 0, "nom_1");
    flip_and_wait(5, 1, 5, 0, 0, 0, 0, "nom_2");
    flip_and_wait(5, 1, 5, 0, 0, 0, 0, "nom_3");
    flip_and_wait(5, 1, 5, 0, 0, 1, 0, "nom_4");
    flip_and_wait(5, 1, 5, 0, 0, 1, 0, "nom_5");
  endtask

  task automatic test_tolerance();
    flip_and_wait(4, 1, 5, 0, 0, 1, 0, "tol_5");
    flip_and_wait(6, 1, 4, 0, 0, 1, 0, "tol_4");
    flip_and_wait(3, 1, 6, 0, 0, 1, 0, "tol_6");
    flip_and_wait(7, 1, 3, 1, 0, 0, 1, "tol_3_short");
    flip_and_wait(5, 1, 7, 0, 1, 0, 2, "tol_7_long");
    flip_and_wait(5, 1, 5, 0, 0, 0, 2, "tol_recover");
  endtask

  task automatic test_timeout();
    toggle_in = ~toggle_in;
    for (int i = 1; i <= 12; i++) begin
      step();
      vectors++;
      if (period_valid !== (i == 3)) begin
        miscompares++;
        $display("FAIL timeout step%0d period_valid got %b want %b", i, period_valid, (i == 3));
      end
      vectors++;
      if (too_long !== (i == 10)) begin
        miscompares++;
        $display("FAIL timeout step%0d too_long got %b want %b", i, too_long, (i == 10));
      end
      vectors++;
      if (too_short !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout step%0d too_short got %b want 0", i, too_short);
      end
      if (i >= 3) begin
        vectors++;
        if (err_count !== ((i >= 10) ? 8'd3 : 8'd2)) begin
          miscompares++;
          $display("FAIL timeout step%0d err_count got %0d want %0d", i, err_count, (i >= 10) ? 3 : 2);
        end
        vectors++;
        if (lock !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout step%0d lock got %b want 0", i, lock);
        end
      end
    end
    flip_and_wait(5, 0, 0, 0, 0, 0, 3, "timeout_rearm");
    flip_and_wait(5, 1, 5, 0, 0, 0, 3, "timeout_measure");
  endtask

  task automatic test_enable_drop();
    flip_and_wait(5, 1, 5, 0, 0, 0, 3, "en_run2");
    flip_and_wait(5, 1, 5, 0, 0, 0, 3, "en_run3");
    flip_and_wait(5, 1, 5, 0, 0, 1, 3, "en_locked");
    toggle_in = ~toggle_in;
    step();
    step();
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) toggle_in = ~toggle_in;
      step();
      vectors++;
      if ({period_valid, too_short, too_long, lock} !== 4'b0000 || err_count !== 8'd3) begin
        miscompares++;
        $display("FAIL en_drop cyc%0d v=%b s=%b l=%b lock=%b err=%0d want 0 0 0 0 3",
                 i, period_valid, too_short, too_long, lock, err_count);
      end
    end
    enable = 1'b1;
    step();
    step();
    flip_and_wait(5, 0, 0, 0, 0, 0, 3, "en_rearm");
    flip_and_wait(5, 1, 5, 0, 0, 0, 3, "en_measure");
  endtask

  task automatic test_saturation();
    int exp_err;
    flip_and_wait(3, 1, 5, 0, 0, 0, 3, "sat_first");
    exp_err = 3;
    for (int n = 1; n < 300; n++) begin
      if (exp_err < 255) exp_err++;
      flip_and_wait(3, 1, 3, 1, 0, 0, exp_err, "sat");
    end
    vectors++;
    if (err_count !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_final err_count got %0d want 255", err_count);
    end
  endtask

  task automatic test_reset_midop();
    toggle_in = ~toggle_in;
    step();
    step();
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset_async");
    toggle_in = 1'b0;
    #3 reset_n = 1'b1;
    repeat (3) step();
    flip_and_wait(5, 0, 0, 0, 0, 0, 0, "post_reset_arm");
    flip_and_wait(5, 1, 5, 0, 0, 0, 0, "post_reset_measure");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_tolerance();
    test_timeout();
    test_enable_drop();
    test_saturation();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
